// File: rtl/sseg4_capture.sv
// Rebuilds the value shown on a 4-digit multiplexed seven-segment display from its pins.
// Optional macro SSEG_CAPTURE_DP_EN adds o_dp, the per-digit decimal points of the last frame.
module sseg4_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 2**20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_sseg_n,
    input  logic [3:0]  i_ldsel,
    output logic [13:0] o_bin,
    output logic        o_hi,
    output logic        o_err,
    output logic        o_valid,
`ifdef SSEG_CAPTURE_DP_EN
    output logic [3:0]  o_dp,
`endif
    output logic        o_timeout
);

    localparam int unsigned ToW = $clog2(FRAME_TIMEOUT);
    localparam logic [ToW-1:0] ToMax = ToW'(FRAME_TIMEOUT - 1);
    localparam logic [7:0] StabMax = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StConv, StDone} state_e;

    state_e state_q, state_d;

    logic [7:0]       sseg_q, sseg_prev_q;
    logic [3:0]       ldsel_q, ldsel_prev_q;
    logic [7:0]       stab_q, stab_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  slot_q, slot_d;
    logic             fhi_q, fhi_d, ferr_q, ferr_d;
    logic [3:0][3:0]  conv_dig_q, conv_dig_d;
    logic             conv_hi_q, conv_hi_d, conv_err_q, conv_err_d;
    logic [13:0]      acc_q, acc_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [13:0]      bin_q, bin_d;
    logic             hi_q, hi_d, err_q, err_d, valid_q, valid_d;
`ifdef SSEG_CAPTURE_DP_EN
    logic [3:0]       fdp_q, fdp_d, conv_dp_q, conv_dp_d, dp_q, dp_d;
`endif

    logic       changed, fire, go;
    logic       sel_ok;
    logic [1:0] sel_idx;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       g_hi, g_err;

    assign changed = {sseg_q, ldsel_q} != {sseg_prev_q, ldsel_prev_q};

    always_comb begin
        stab_d = stab_q;
        if (changed) begin
            stab_d = 8'd0;
        end else if (stab_q != StabMax) begin
            stab_d = stab_q + 8'd1;
        end
    end

    // Fire once on arrival at the threshold; a saturated counter never re-fires.
    assign fire = sel_ok && (stab_d == StabMax) && (changed || (stab_q != StabMax));

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (ldsel_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    always_comb begin
        seg   = ~sseg_q[6:0];
        dig   = 4'd0;
        g_hi  = 1'b0;
        g_err = 1'b0;
        case (seg)
            7'h3F:   dig = 4'd0;
            7'h06:   dig = 4'd1;
            7'h5B:   dig = 4'd2;
            7'h4F:   dig = 4'd3;
            7'h66:   dig = 4'd4;
            7'h6D:   dig = 4'd5;
            7'h7D:   dig = 4'd6;
            7'h07:   dig = 4'd7;
            7'h7F:   dig = 4'd8;
            7'h6F:   dig = 4'd9;
            7'h00:   dig = 4'd0;
            7'h76:   g_hi = 1'b1;
            default: g_err = 1'b1;
        endcase
    end

    assign go = (state_q == StScan) && (mask_q == 4'hF);

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        slot_d     = slot_q;
        fhi_d      = fhi_q;
        ferr_d     = ferr_q;
        conv_dig_d = conv_dig_q;
        conv_hi_d  = conv_hi_q;
        conv_err_d = conv_err_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        bin_d      = bin_q;
        hi_d       = hi_q;
        err_d      = err_q;
        valid_d    = 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
        fdp_d      = fdp_q;
        conv_dp_d  = conv_dp_q;
        dp_d       = dp_q;
`endif

        if (state_q == StScan && to_q != ToMax) begin
            to_d = to_q + ToW'(1);
        end

        if (go) begin
            conv_dig_d = slot_q;
            conv_hi_d  = fhi_q;
            conv_err_d = ferr_q;
            mask_d     = 4'd0;
            fhi_d      = 1'b0;
            ferr_d     = 1'b0;
            acc_d      = 14'd0;
            cnt_d      = 2'd0;
            to_d       = '0;
            state_d    = StConv;
`ifdef SSEG_CAPTURE_DP_EN
            conv_dp_d  = fdp_q;
`endif
        end

        // Capture runs in every state, so the next frame builds up during conversion.
        if (fire) begin
            slot_d[sel_idx] = dig;
            mask_d[sel_idx] = 1'b1;
            if (g_hi) fhi_d = 1'b1;
            if (g_err) ferr_d = 1'b1;
`ifdef SSEG_CAPTURE_DP_EN
            fdp_d[sel_idx] = ~sseg_q[7];
`endif
        end

        case (state_q)
            StConv: begin
                acc_d = (acc_q << 3) + (acc_q << 1) + 14'(conv_dig_q[2'd3 - cnt_q]);
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = StDone;
            end
            StDone: begin
                valid_d = 1'b1;
                hi_d    = conv_hi_q;
                err_d   = conv_err_q;
                if (!conv_err_q) bin_d = conv_hi_q ? 14'd0 : acc_q;
`ifdef SSEG_CAPTURE_DP_EN
                dp_d    = conv_dp_q;
`endif
                state_d = StScan;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StScan;
            sseg_q       <= 8'hFF;
            sseg_prev_q  <= 8'hFF;
            ldsel_q      <= 4'hF;
            ldsel_prev_q <= 4'hF;
            stab_q       <= 8'd0;
            mask_q       <= 4'd0;
            slot_q       <= '0;
            fhi_q        <= 1'b0;
            ferr_q       <= 1'b0;
            conv_dig_q   <= '0;
            conv_hi_q    <= 1'b0;
            conv_err_q   <= 1'b0;
            acc_q        <= 14'd0;
            cnt_q        <= 2'd0;
            to_q         <= '0;
            bin_q        <= 14'd0;
            hi_q         <= 1'b0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
            fdp_q        <= 4'd0;
            conv_dp_q    <= 4'd0;
            dp_q         <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            sseg_q       <= i_sseg_n;
            sseg_prev_q  <= sseg_q;
            ldsel_q      <= i_ldsel;
            ldsel_prev_q <= ldsel_q;
            stab_q       <= stab_d;
            mask_q       <= mask_d;
            slot_q       <= slot_d;
            fhi_q        <= fhi_d;
            ferr_q       <= ferr_d;
            conv_dig_q   <= conv_dig_d;
            conv_hi_q    <= conv_hi_d;
            conv_err_q   <= conv_err_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            bin_q        <= bin_d;
            hi_q         <= hi_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
`ifdef SSEG_CAPTURE_DP_EN
            fdp_q        <= fdp_d;
            conv_dp_q    <= conv_dp_d;
            dp_q         <= dp_d;
`endif
        end
    end

    assign o_bin     = bin_q;
    assign o_hi      = hi_q;
    assign o_err     = err_q;
    assign o_valid   = valid_q;
    assign o_timeout = (to_q == ToMax);
`ifdef SSEG_CAPTURE_DP_EN
    assign o_dp      = dp_q;
`endif

endmodule

// File: tb/tb_sseg4_capture.sv
// Directed bench for sseg4_capture: frame table plus latency, timeout and reset sequences.
module tb_sseg4_capture;

    localparam int unsigned Stable  = 4;
    localparam int unsigned Timeout = 128;

    localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
    localparam logic [6:0] G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07, G8 = 7'h7F, G9 = 7'h6F;
    localparam logic [6:0] GB = 7'h00, GH = 7'h76, GX = 7'h49;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sseg_n;
    logic [3:0]  ldsel;
    logic [13:0] bin;
    logic        hi, err, valid, tmo;
`ifdef SSEG_CAPTURE_DP_EN
    logic [3:0]  dp;
    logic [3:0]  last_dp;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int vcnt      = 0;
    logic [13:0] last_bin;
    logic        last_hi, last_err;

    always #5 clk = ~clk;

    sseg4_capture #(
        .STABLE_CYCLES(Stable),
        .FRAME_TIMEOUT(Timeout)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_sseg_n (sseg_n),
        .i_ldsel  (ldsel),
        .o_bin    (bin),
        .o_hi     (hi),
        .o_err    (err),
        .o_valid  (valid),
`ifdef SSEG_CAPTURE_DP_EN
        .o_dp     (dp),
`endif
        .o_timeout(tmo)
    );

    always @(negedge clk) begin
        if (valid) begin
            vcnt     <= vcnt + 1;
            last_bin <= bin;
            last_hi  <= hi;
            last_err <= err;
`ifdef SSEG_CAPTURE_DP_EN
            last_dp  <= dp;
`endif
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else pass_cnt++;
    endtask

    // Entered and left 2 ns after a rising edge.
    task automatic drive(input logic [3:0] sel, input logic [7:0] s, input int n);
        ldsel  = sel;
        sseg_n = s;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_digit(input int i, input logic [6:0] g, input logic dpb);
        logic [3:0] sel;
        sel = 4'b0001 << i;
        drive(~sel, ~{dpb, g}, 8);
        drive(4'hF, 8'hFF, 2);
    endtask

    task automatic send_frame(input logic [6:0] g3, input logic [6:0] g2, input logic [6:0] g1,
                              input logic [6:0] g0, input logic [3:0] dpv);
        send_digit(0, g0, dpv[0]);
        send_digit(1, g1, dpv[1]);
        send_digit(2, g2, dpv[2]);
        send_digit(3, g3, dpv[3]);
    endtask

    typedef struct {
        logic [6:0]  g3, g2, g1, g0;
        logic [3:0]  dpv;
        logic [13:0] bin;
        logic        hi, err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0;
        int first;

        vecs[0] = '{G1, G2, G3, G4, 4'b0000, 14'd1234, 1'b0, 1'b0};
        vecs[1] = '{GB, GB, GB, G9, 4'b0000, 14'd9,    1'b0, 1'b0};
        vecs[2] = '{G9, G9, G9, G9, 4'b0000, 14'd9999, 1'b0, 1'b0};
        vecs[3] = '{G5, G6, GH, G7, 4'b0000, 14'd0,    1'b1, 1'b0};
        vecs[4] = '{G1, G2, G3, G4, 4'b0000, 14'd1234, 1'b0, 1'b0};
        vecs[5] = '{G1, GX, G3, G4, 4'b0000, 14'd1234, 1'b0, 1'b1};
        vecs[6] = '{G8, G0, G7, G6, 4'b0100, 14'd8076, 1'b0, 1'b0};
        vecs[7] = '{G0, G0, G0, G0, 4'b0000, 14'd0,    1'b0, 1'b0};

        rst    = 1'b1;
        sseg_n = 8'hFF;
        ldsel  = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        check("reset_bin", int'(bin), 0);
        check("reset_hi", int'(hi), 0);
        check("reset_err", int'(err), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_timeout", int'(tmo), 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Latency: last digit sampled Stable+1 edges after it appears, o_valid 6 edges later.
        send_digit(0, G5, 1'b0);
        send_digit(1, G6, 1'b0);
        send_digit(2, G7, 1'b0);
        v0     = vcnt;
        first  = 0;
        ldsel  = 4'b0111;
        sseg_n = ~{1'b0, G8};
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (valid && first == 0) first = k;
        end
        #1;
        drive(4'hF, 8'hFF, 2);
        repeat (10) @(posedge clk);
        #2;
        check("latency_edges", first, int'(Stable) + 7);
        check("latency_pulses", vcnt - v0, 1);
        check("latency_bin", int'(last_bin), 8765);

        for (int i = 0; i < 8; i++) begin
            v0 = vcnt;
            send_frame(vecs[i].g3, vecs[i].g2, vecs[i].g1, vecs[i].g0, vecs[i].dpv);
            repeat (15) @(posedge clk);
            #2;
            check($sformatf("vec%0d_pulses", i), vcnt - v0, 1);
            check($sformatf("vec%0d_bin", i), int'(last_bin), int'(vecs[i].bin));
            check($sformatf("vec%0d_hi", i), int'(last_hi), int'(vecs[i].hi));
            check($sformatf("vec%0d_err", i), int'(last_err), int'(vecs[i].err));
            check($sformatf("vec%0d_timeout", i), int'(tmo), 0);
`ifdef SSEG_CAPTURE_DP_EN
            check($sformatf("vec%0d_dp", i), int'(last_dp), int'(vecs[i].dpv));
`endif
        end

        // Segment toggling every 2 cycles never settles: no capture, timeout expires.
        v0 = vcnt;
        for (int k = 0; k < 80; k++) begin
            drive(4'b1110, (k % 2 == 0) ? 8'hF9 : 8'hF8, 2);
        end
        drive(4'hF, 8'hFF, 2);
        check("toggle_pulses", vcnt - v0, 0);
        check("toggle_timeout", int'(tmo), 1);

        v0 = vcnt;
        send_frame(G1, G2, G3, G4, 4'b0000);
        repeat (15) @(posedge clk);
        #2;
        check("recover_pulses", vcnt - v0, 1);
        check("recover_bin", int'(last_bin), 1234);
        check("recover_timeout", int'(tmo), 0);

        // Reset while converting: frame dropped, outputs cleared.
        send_digit(0, G4, 1'b0);
        send_digit(1, G3, 1'b0);
        send_digit(2, G2, 1'b0);
        v0     = vcnt;
        ldsel  = 4'b0111;
        sseg_n = ~{1'b0, G1};
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midconv_bin", int'(bin), 0);
        check("midconv_hi", int'(hi), 0);
        check("midconv_err", int'(err), 0);
        check("midconv_valid", int'(valid), 0);
        check("midconv_timeout", int'(tmo), 0);
        #1;
        rst = 1'b0;
        drive(4'hF, 8'hFF, 2);
        repeat (15) @(posedge clk);
        #2;
        check("midconv_pulses", vcnt - v0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sseg4_capture.md
Name: sseg4_capture

Overview:
- Receive-side counterpart of the 4-digit multiplexed seven-segment driver. It watches the active-low segment bus and active-low digit-select lines and rebuilds the displayed value.
- Samples each digit once its lines are stable, decodes the glyphs to BCD, assembles a full 4-digit frame, and converts it to a 14-bit binary value.
- Used in loopback self-test and on-board checking of display output. Sits in parallel with the display pins in top-level builds.

Parameters:
- STABLE_CYCLES, 4, consecutive cycles that sseg and ldsel must be unchanged before a digit is sampled (range 1..255).
- FRAME_TIMEOUT, 2**20, cycles without a completed frame before o_timeout asserts (range >= 16).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_sseg_n  input  8  segment bus {dp,g,f,e,d,c,b,a}, active-low
- i_ldsel  input  4  digit select, active-low one-hot; bit3 = most significant digit
- o_bin  output  14  last converted value, 0..9999
- o_hi  output  1  last frame contained the "H" glyph
- o_err  output  1  last frame contained an undecodable glyph
- o_valid  output  1  one-cycle pulse when o_bin/o_hi/o_err update
- o_timeout  output  1  no frame completed within FRAME_TIMEOUT cycles

Behaviour:
- Reset: i_rst is sampled on the rising edge of i_clk. On reset, o_bin=0, o_hi=0, o_err=0, o_valid=0, o_timeout=0; capture mask, stability counter and timeout counter clear; FSM goes to SCAN.
- Inputs are registered once on entry.
- Stability:
  - The counter increments while {sseg_n, ldsel} equals the previous cycle's value; it resets to 0 on any change.
  - A digit is sampled on the cycle the counter reaches STABLE_CYCLES-1.
  - Only one sample is taken per stable period; the counter saturates.
- Select validity:
  - ldsel must be exactly one-hot-low to be sampled.
  - 4'b1111 (blanking interval) and multi-low patterns are ignored and nothing is captured.
- Glyph decode: on active-high gfedcba, dp is ignored.
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 00 (blank) = 0.
  - 76 = "H": digit value 0 and sets the frame hi flag.
  - Any other code: digit value 0 and sets the frame err flag.
- Capture: the decoded digit is written to slot[ldsel index] and the corresponding mask bit is set. A repeat of the same digit before the frame completes overwrites the slot.
- FSM states: SCAN, CONV, DONE.
  - SCAN -> CONV when mask==4'b1111. On that transition, slots and flags copy into the conversion registers and the mask, frame flags and timeout counter clear.
  - CONV: 4 cycles, MSD first, acc = acc*10 + digit. The multiply by 10 is implemented as (acc<<3)+(acc<<1) in 14 bits. 9999 must not overflow.
  - DONE: for 1 cycle, o_bin<=acc, o_hi<=hi flag, o_err<=err flag, o_valid=1; then SCAN.
  - If o_hi=1, o_bin=0.
  - If o_err=1, o_bin holds its previous value; o_hi and o_err are still updated.
- Latency: o_valid is high exactly 6 cycles after the registered sample cycle that completed the mask (1 transition + 4 CONV + 1 DONE).
- Concurrency: capture continues in CONV and DONE into the now-cleared mask, so a frame completing during CONV/DONE is held. Its SCAN->CONV transition occurs on the cycle after DONE.
- Timeout:
  - The counter increments every cycle while in SCAN and saturates.
  - o_timeout=1 when it reaches FRAME_TIMEOUT-1.
  - It clears to 0 together with the counter on the next frame completion.
- Reset mid-CONV discards the frame; o_valid does not pulse.

Optional Feature:
- SSEG_CAPTURE_DP_EN defined:
  - Adds output o_dp [3:0], reset 0. It holds the active-high dp bit of each digit from the last frame and updates at o_valid.
  - dp is captured alongside the glyph.
- Not defined: o_dp is absent, dp is ignored, and there is no extra logic.

Test Plan:
- Drive digits 1,2,3,4 (ldsel E,D,B,7 active-low order bit0..bit3 = 4,3,2,1), each held 8 cycles with 2-cycle blanking -> o_valid pulses once, o_bin=1234, o_hi=0, o_err=0.
- Frame of blank,blank,blank,9 (digit0=9) -> o_bin=9. Then frame 9999 -> o_bin=9999 with no overflow.
- Frame with glyph 0x76 on digit1 -> o_hi=1, o_bin=0, o_valid=1.
- Digit2 = code 0x49 (invalid) with previous o_bin=1234 -> o_err=1, o_bin stays 1234.
- Toggle a segment every 2 cycles with STABLE_CYCLES=4 -> no capture and no o_valid. With no frame for FRAME_TIMEOUT cycles -> o_timeout=1; the next good frame clears it.
- Assert i_rst during CONV -> no o_valid, all outputs 0 on the next cycle. With SSEG_CAPTURE_DP_EN, dp set on digit2 -> o_dp=4'b0100.
